// File: rtl/apb_to_obi_bridge.sv
// rtl/apb_to_obi_bridge.sv - APB completer issuing one OBI manager transaction per APB transfer
module apb_to_obi_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [DataWidth-1:0]   pwdata_i,
  input  logic [DataWidth/8-1:0] pstrb_i,
  output logic                   pready_o,
  output logic [DataWidth-1:0]   prdata_o,
  output logic                   pslverr_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  // Counter must be able to hold TimeoutCycles itself; keep at least one bit
  localparam int unsigned CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TimeoutCycles);
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT_R,
    COMPLETE,
    DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic [StrbWidth-1:0]   be_q, be_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth-1:0]   prdata_q, prdata_d;
  logic                   pslverr_q, pslverr_d;
  logic                   pending_q, pending_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;

  // Next-state and datapath update: capture on setup, hold req until gnt,
  // wait for rvalid (or timeout), present the response, drain a late rvalid
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    pending_d = pending_q;
    cnt_d     = '0;

    unique case (state_q)
      IDLE: begin
        // Only a fresh setup phase starts a transfer; a held access phase is ignored
        if (psel_i && !penable_i) begin
          addr_d    = paddr_i;
          we_d      = pwrite_i;
          be_d      = pwrite_i ? pstrb_i : {StrbWidth{1'b1}};
          wdata_d   = pwrite_i ? pwdata_i : '0;
          prdata_d  = '0;
          pslverr_d = 1'b0;
          req_d     = 1'b1;
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        // No timeout here: an OBI request may not be withdrawn before gnt
        if (obi_gnt_i) begin
          req_d   = 1'b0;
          state_d = WAIT_R;
        end
      end

      WAIT_R: begin
        cnt_d = cnt_q + CntWidth'(1);
        // A response landing on the timeout cycle still wins
        if (obi_rvalid_i) begin
          prdata_d  = we_q ? '0 : obi_rdata_i;
          pslverr_d = obi_err_i;
          cnt_d     = '0;
          state_d   = COMPLETE;
        end else if (TimeoutEn && (cnt_q == TimeoutVal)) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pending_d = 1'b1;
          cnt_d     = '0;
          state_d   = COMPLETE;
        end
      end

      COMPLETE: begin
        // Response is offered for this single cycle; an aborted APB transfer
        // simply never sees it
        state_d = pending_q ? DRAIN : IDLE;
      end

      DRAIN: begin
        // Swallow the late response of a timed-out transaction
        if (obi_rvalid_i) begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pready_o    = (state_q == COMPLETE) && psel_i && penable_i;
  assign prdata_o    = prdata_q;
  assign pslverr_o   = pslverr_q;
  assign obi_req_o   = req_q;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// tb/tb_apb_to_obi_bridge.sv - scoreboard bench for apb_to_obi_bridge
module tb_apb_to_obi_bridge;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic [3:0]  pstrb_i = '0;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = '0;
  logic        obi_err_i = 1'b0;

  apb_to_obi_bridge #(
    .AddrWidth(32),
    .DataWidth(32),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .psel_i(psel_i),
    .penable_i(penable_i),
    .pwrite_i(pwrite_i),
    .paddr_i(paddr_i),
    .pwdata_i(pwdata_i),
    .pstrb_i(pstrb_i),
    .pready_o(pready_o),
    .prdata_o(prdata_o),
    .pslverr_o(pslverr_o),
    .obi_req_o(obi_req_o),
    .obi_gnt_i(obi_gnt_i),
    .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o),
    .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i(obi_rdata_i),
    .obi_err_i(obi_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          hold;
  } req_exp_t;

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          lat;
    int          setup_cyc;
  } rsp_exp_t;

  typedef struct {
    int   gnt_dly;
    int   rv_dly;
    logic err;
    logic timeout;
    int   late;
  } plan_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  plan_t    plan_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 32'h0;
  endfunction

  // OBI subordinate model: follows the per-transaction plan queued by the stimulus
  initial begin
    plan_t p;
    logic [31:0] a;
    forever begin
      @(posedge clk_i); #1;
      if (rst_ni && obi_req_o && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        repeat (p.gnt_dly) begin @(posedge clk_i); #1; end
        obi_gnt_i = 1'b1;
        a = obi_addr_o;
        if (obi_we_o) dev_mem[a] = merge(dev_rd(a), obi_wdata_o, obi_be_o);
        @(posedge clk_i); #1;
        obi_gnt_i = 1'b0;
        if (p.timeout) begin
          repeat (p.late) begin @(posedge clk_i); #1; end
          obi_rdata_i = 32'hFFFF_FFFF;
          obi_err_i   = 1'b1;
        end else begin
          repeat (p.rv_dly - 1) begin @(posedge clk_i); #1; end
          obi_rdata_i = dev_rd(a);
          obi_err_i   = p.err;
        end
        obi_rvalid_i = 1'b1;
        @(posedge clk_i); #1;
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
        obi_rdata_i  = '0;
      end
    end
  end

  // OBI request monitor
  initial begin
    req_exp_t cur;
    bit in_req;
    int held;
    in_req = 0;
    held = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        in_req = 0;
      end else if (obi_req_o) begin
        if (!in_req) begin
          in_req = 1;
          held = 0;
          if (req_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL obi_unexpected_req: got addr 0x%08h want none", obi_addr_o);
            cur = '{addr: obi_addr_o, we: obi_we_o, be: obi_be_o, wdata: obi_wdata_o, hold: 0};
          end else begin
            cur = req_q.pop_front();
          end
        end
        chk("obi_addr", obi_addr_o, cur.addr);
        chk("obi_we", 32'(obi_we_o), 32'(cur.we));
        chk("obi_be", 32'(obi_be_o), 32'(cur.be));
        chk("obi_wdata", obi_wdata_o, cur.wdata);
        held++;
        if (obi_gnt_i) begin
          chk("obi_req_cycles", 32'(held), 32'(cur.hold + 1));
          in_req = 0;
        end
      end
    end
  end

  // APB response monitor
  initial begin
    rsp_exp_t r;
    forever begin
      @(negedge clk_i);
      if (pready_o) begin
        if (rsp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL apb_unexpected_pready: got prdata 0x%08h want no response", prdata_o);
        end else begin
          r = rsp_q.pop_front();
          chk("prdata", prdata_o, r.prdata);
          chk("pslverr", 32'(pslverr_o), 32'(r.slverr));
          chk("latency", 32'(cyc - r.setup_cyc), 32'(r.lat));
        end
      end
    end
  end

  task automatic prep(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int g, input int rv, input logic err,
                      input logic tmo, output rsp_exp_t rs);
    req_exp_t rq;
    logic [31:0] old;
    plan_q.push_back('{gnt_dly: g, rv_dly: rv, err: err, timeout: tmo, late: 18});
    rq.addr  = addr;
    rq.we    = we;
    rq.be    = we ? strb : 4'hF;
    rq.wdata = we ? wdata : 32'h0;
    rq.hold  = g;
    req_q.push_back(rq);
    old = ref_rd(addr);
    if (we) begin
      ref_mem[addr] = merge(old, wdata, strb);
      rs.prdata = 32'h0;
    end else begin
      rs.prdata = tmo ? 32'h0 : old;
    end
    rs.slverr    = err | tmo;
    rs.lat       = tmo ? (3 + g + TO) : (2 + g + rv);
    rs.setup_cyc = cyc;
  endtask

  task automatic apb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int g, input int rv, input logic err,
                          input logic tmo);
    rsp_exp_t rs;
    int waited;
    prep(we, addr, wdata, strb, g, rv, err, tmo, rs);
    rsp_q.push_back(rs);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = we;
    paddr_i = addr; pwdata_i = wdata; pstrb_i = strb;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
    end while (!pready_o && waited < 60);
    if (!pready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL pready_wait: got no pready after %0d cycles want pready", waited);
    end
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_exp_t rs;
    logic [31:0] a;
    logic w;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_pready", 32'(pready_o), 32'h0);
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    chk("rst_req", 32'(obi_req_o), 32'h0);
    chk("rst_addr", obi_addr_o, 32'h0);
    chk("rst_we", 32'(obi_we_o), 32'h0);
    chk("rst_be", 32'(obi_be_o), 32'h0);
    chk("rst_wdata", obi_wdata_o, 32'h0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    ref_mem[32'h0002_0004] = 32'h1234_5678; dev_mem[32'h0002_0004] = 32'h1234_5678;
    ref_mem[32'h0003_0008] = 32'h1122_3344; dev_mem[32'h0003_0008] = 32'h1122_3344;

    apb_xfer(1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 0, 1, 1'b0, 1'b0);
    apb_xfer(1'b0, 32'h0002_0004, 32'h5555_AAAA, 4'h0, 4, 1, 1'b0, 1'b0);
    apb_xfer(1'b1, 32'h0003_0008, 32'h00AB_0000, 4'h4, 1, 2, 1'b0, 1'b0);
    apb_xfer(1'b0, 32'h0003_0008, 32'h0, 4'h0, 0, 1, 1'b0, 1'b0);
    apb_xfer(1'b0, 32'h0001_0000, 32'h0, 4'h0, 2, 3, 1'b1, 1'b0);
    apb_xfer(1'b0, 32'h0002_0004, 32'h0, 4'h0, 0, 2, 1'b0, 1'b0);
    apb_xfer(1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, 9, 1'b0, 1'b0);

    // Timeout, then a setup offered during DRAIN must be ignored
    apb_xfer(1'b0, 32'h0002_0004, 32'h0, 4'h0, 1, 1, 1'b0, 1'b1);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h0001_0000;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("drain_pready", 32'(pready_o), 32'h0);
      chk("drain_req", 32'(obi_req_o), 32'h0);
    end
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (6) begin @(posedge clk_i); #1; end
    chk("drain_prdata_hold", prdata_o, 32'h0);
    chk("drain_pslverr_hold", 32'(pslverr_o), 32'h1);
    apb_xfer(1'b0, 32'h0002_0004, 32'h0, 4'h0, 0, 1, 1'b0, 1'b0);

    // Reset during WAIT_R, stale rvalid afterwards
    prep(1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, 6, 1'b0, 1'b0, rs);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h0001_0000;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_pready", 32'(pready_o), 32'h0);
    chk("arst_req", 32'(obi_req_o), 32'h0);
    chk("arst_addr", obi_addr_o, 32'h0);
    chk("arst_be", 32'(obi_be_o), 32'h0);
    chk("arst_wdata", obi_wdata_o, 32'h0);
    chk("arst_prdata", prdata_o, 32'h0);
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      chk("stale_pready", 32'(pready_o), 32'h0);
      chk("stale_req", 32'(obi_req_o), 32'h0);
      chk("stale_pslverr", 32'(pslverr_o), 32'h0);
    end
    chk("stale_prdata", prdata_o, 32'h0);
    @(posedge clk_i); #1;
    apb_xfer(1'b0, 32'h0001_0000, 32'h0, 4'h0, 1, 1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = 32'h0004_0000 + 32'(4 * $urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      apb_xfer(w, a, $urandom, w ? 4'($urandom_range(1, 15)) : 4'h0,
               int'($urandom_range(0, 3)), int'($urandom_range(1, 9)),
               (!w && $urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk_i); #1; end
    end

    repeat (4) @(posedge clk_i);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
    chk("req_queue_empty", 32'(req_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
